// File: rtl/uart_rx_monitor_pkg.sv
// Shared types and helpers for the UART receive monitor.
package uart_mon_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP,
      BRK
   } state_e;

   // FIFO entry is {ferr, perr, data}
   function automatic int entry_w(input int data_bits);
      return data_bits + 2;
   endfunction

endpackage

// File: rtl/uart_rx_monitor_if.sv
// Valid/ready read port of the UART receive monitor character FIFO.
interface uart_rx_monitor_if #(
   parameter int DATA_BITS = 8
) ();
   logic                 rd_valid_o;
   logic                 rd_ready_i;
   logic [DATA_BITS-1:0] rd_data_o;
   logic                 rd_perr_o;
   logic                 rd_ferr_o;

   modport master (
      output rd_valid_o, rd_data_o, rd_perr_o, rd_ferr_o,
      input  rd_ready_i
   );

   modport slave (
      input  rd_valid_o, rd_data_o, rd_perr_o, rd_ferr_o,
      output rd_ready_i
   );
endinterface

// File: rtl/uart_rx_monitor_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is
// only accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr, rptr;
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty.
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (srst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: oversampled frame decoder feeding a character FIFO,
// with saturating frame/error counters and a sticky overflow flag.
module uart_rx_monitor
   import uart_mon_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              rx_i,
   input  logic              en_i,
   input  logic              clr_i,
   uart_rx_monitor_if.master rd,
   output logic              busy_o,
   output logic              overflow_o,
   output logic [CNT_W-1:0]  frame_cnt_o,
   output logic [CNT_W-1:0]  err_cnt_o
);
   localparam int      EW    = entry_w(DATA_BITS);
   localparam int      TW    = $clog2(CLKS_PER_BIT);
   localparam int      BW    = $clog2(DATA_BITS);
   localparam parity_e PMODE = parity_e'(PARITY);
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT/2 - 1);
   localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

   state_e               state;
   logic                 rx_s1, rxs;
   logic [TW-1:0]        tmr;
   logic [BW-1:0]        bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr, ferr;
   logic                 tick, push, pop, ferr_now, par_err;
   logic                 fifo_full, fifo_empty;
   logic [EW-1:0]        fifo_rdata;

   always_ff @(posedge clk) begin
      if (srst) begin
         rx_s1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         rx_s1 <= rx_i;
         rxs   <= rx_s1;
      end
   end

   assign tick     = (tmr == '0);
   assign push     = (state == STOP) && tick && (stop_cnt == 1'(STOP_BITS - 1));
   assign ferr_now = ferr | ~rxs;
   assign par_err  = (PMODE == PAR_ODD) ? ~(^{shreg, rxs}) : (^{shreg, rxs});
   assign busy_o   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (srst) begin
         state    <= IDLE;
         tmr      <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
      end else begin
         tmr <= tick ? T_FULL : tmr - TW'(1);
         case (state)
            IDLE: if (en_i && !rxs) begin
               state <= START;
               tmr   <= T_HALF;
            end
            START: if (tick) begin
               if (rxs) state <= IDLE;
               else begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: if (tick) begin
               shreg   <= {rxs, shreg[DATA_BITS-1:1]};
               bit_cnt <= bit_cnt + BW'(1);
               if (bit_cnt == BW'(DATA_BITS - 1)) begin
                  state    <= (PMODE == PAR_NONE) ? STOP : PAR;
                  perr     <= 1'b0;
                  ferr     <= 1'b0;
                  stop_cnt <= 1'b0;
               end
            end
            PAR: if (tick) begin
               perr  <= par_err;
               state <= STOP;
            end
            STOP: if (tick) begin
               if (!rxs) ferr <= 1'b1;
               stop_cnt <= 1'b1;
               // A low line at the final stop sample is a break: wait it out.
               if (push) state <= rxs ? IDLE : BRK;
            end
            BRK: if (rxs) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (srst || clr_i) begin
         frame_cnt_o <= '0;
         err_cnt_o   <= '0;
         overflow_o  <= 1'b0;
      end else if (push) begin
         if (frame_cnt_o != '1) frame_cnt_o <= frame_cnt_o + CNT_W'(1);
         if ((perr || ferr_now) && err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
         if (fifo_full && !pop) overflow_o <= 1'b1;
      end
   end

   assign pop           = rd.rd_valid_o && rd.rd_ready_i;
   assign rd.rd_valid_o = !fifo_empty;
   assign rd.rd_data_o  = fifo_rdata[DATA_BITS-1:0];
   assign rd.rd_perr_o  = fifo_rdata[DATA_BITS];
   assign rd.rd_ferr_o  = fifo_rdata[DATA_BITS+1];

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .srst  (srst),
      .push  (push),
      .wdata ({ferr_now, perr, shreg}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
endmodule

// File: tb/tb_uart_rx_monitor.sv
// Scoreboard bench for uart_rx_monitor: an 8N1 instance (a) and an 8E1 instance (b).
module tb_uart_rx_monitor;
   localparam int CPB = 16;
   localparam int DB  = 8;

   typedef struct packed {
      logic       ferr;
      logic       perr;
      logic [7:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        srst = 1'b1;
   logic        rx_a = 1'b1, rx_b = 1'b1, en = 1'b1, clr_a = 1'b0, clr_b = 1'b0;
   logic        busy_a, busy_b, ovf_a, ovf_b;
   logic [15:0] fcnt_a, ecnt_a, fcnt_b, ecnt_b;
   int          tests = 0, fails = 0, cyc = 0, rise_a = 0, t0 = 0;
   logic        prev_va = 1'b0;
   ent_t        q_a[$], q_b[$];
   ent_t        ea, eb;

   uart_rx_monitor_if #(.DATA_BITS(DB)) if_a ();
   uart_rx_monitor_if #(.DATA_BITS(DB)) if_b ();

   uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .STOP_BITS(1),
                     .FIFO_DEPTH(16), .CNT_W(16)) dut_a (
      .clk(clk), .srst(srst), .rx_i(rx_a), .en_i(en), .clr_i(clr_a), .rd(if_a.master),
      .busy_o(busy_a), .overflow_o(ovf_a), .frame_cnt_o(fcnt_a), .err_cnt_o(ecnt_a));

   uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(2), .STOP_BITS(1),
                     .FIFO_DEPTH(16), .CNT_W(16)) dut_b (
      .clk(clk), .srst(srst), .rx_i(rx_b), .en_i(en), .clr_i(clr_b), .rd(if_b.master),
      .busy_o(busy_b), .overflow_o(ovf_b), .frame_cnt_o(fcnt_b), .err_cnt_o(ecnt_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic ent_t mk(input logic f, input logic p, input logic [7:0] d);
      ent_t e;
      e.ferr = f;
      e.perr = p;
      e.data = d;
      return e;
   endfunction

   // Monitors: pop the expected entry whenever a transfer is presented.
   always @(negedge clk) begin
      prev_va <= if_a.rd_valid_o;
      if (if_a.rd_valid_o && !prev_va) rise_a <= cyc;
      if (!srst && if_a.rd_valid_o && if_a.rd_ready_i) begin
         check("A entry expected", int'(q_a.size() > 0), 1);
         if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            check("A rd_data", if_a.rd_data_o, ea.data);
            check("A rd_perr", if_a.rd_perr_o, ea.perr);
            check("A rd_ferr", if_a.rd_ferr_o, ea.ferr);
         end
      end
   end

   always @(negedge clk) begin
      if (!srst && if_b.rd_valid_o && if_b.rd_ready_i) begin
         check("B entry expected", int'(q_b.size() > 0), 1);
         if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            check("B rd_data", if_b.rd_data_o, eb.data);
            check("B rd_perr", if_b.rd_perr_o, eb.perr);
            check("B rd_ferr", if_b.rd_ferr_o, eb.ferr);
         end
      end
   end

   task automatic drive(input int sel, input logic v, input int ncyc);
      if (sel == 0) rx_a = v;
      else rx_b = v;
      repeat (ncyc) @(posedge clk);
      #1;
   endtask

   // par < 0: no parity bit; stop line high is followed by a short idle gap.
   task automatic send(input int sel, input logic [7:0] d, input int par, input logic stop_v);
      drive(sel, 1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(sel, d[i], CPB);
      if (par >= 0) drive(sel, par[0], CPB);
      drive(sel, stop_v, CPB);
      if (stop_v) drive(sel, 1'b1, 4);
   endtask

   task automatic wait_drain(input int sel, input int maxc);
      int n = 0;
      while (((sel == 0) ? q_a.size() : q_b.size()) != 0 && n < maxc) begin
         @(posedge clk);
         n++;
      end
      #1;
      check((sel == 0) ? "A drain" : "B drain", (sel == 0) ? q_a.size() : q_b.size(), 0);
   endtask

   task automatic pulse_clr_a();
      clr_a = 1'b1;
      @(posedge clk);
      #1;
      clr_a = 1'b0;
   endtask

   initial begin
      if_a.rd_ready_i = 1'b1;
      if_b.rd_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", busy_a, 0);
      check("reset rd_valid", if_a.rd_valid_o, 0);
      check("reset rd_data", if_a.rd_data_o, 0);
      check("reset overflow", ovf_a, 0);
      check("reset frame_cnt", fcnt_a, 0);
      check("reset err_cnt", ecnt_a, 0);
      srst = 1'b0;
      @(posedge clk);
      #1;

      // 0xA5 8N1; 2 sync + 1 detect + 8 half-bit + 9*16 = 155 cycles to rd_valid.
      q_a.push_back(mk(1'b0, 1'b0, 8'hA5));
      t0 = cyc;
      send(0, 8'hA5, -1, 1'b1);
      check("A5 rd_valid latency", rise_a - t0, 155);
      check("A5 frame_cnt", fcnt_a, 1);
      check("A5 err_cnt", ecnt_a, 0);

      // Even parity: 0x03 with parity 1 is wrong, 0x07 with parity 1 is right.
      q_b.push_back(mk(1'b0, 1'b1, 8'h03));
      send(1, 8'h03, 1, 1'b1);
      check("B perr err_cnt", ecnt_b, 1);
      q_b.push_back(mk(1'b0, 1'b0, 8'h07));
      send(1, 8'h07, 1, 1'b1);
      check("B good err_cnt", ecnt_b, 1);
      check("B frame_cnt", fcnt_b, 2);

      // Framing error followed by a held-low break.
      q_a.push_back(mk(1'b1, 1'b0, 8'h55));
      send(0, 8'h55, -1, 1'b0);
      drive(0, 1'b0, 40);
      check("break busy", busy_a, 1);
      check("break frame_cnt", fcnt_a, 2);
      check("break err_cnt", ecnt_a, 1);
      drive(0, 1'b1, 20);
      check("break exit busy", busy_a, 0);
      check("break no 2nd frame", fcnt_a, 2);

      // Short low glitch: START sees a high line at mid-bit.
      drive(0, 1'b0, 4);
      drive(0, 1'b1, 4);
      check("glitch busy in START", busy_a, 1);
      drive(0, 1'b1, 20);
      check("glitch busy", busy_a, 0);
      check("glitch frame_cnt", fcnt_a, 2);

      // Overflow: 17 frames with reads stalled.
      pulse_clr_a();
      check("clr frame_cnt", fcnt_a, 0);
      check("clr err_cnt", ecnt_a, 0);
      if_a.rd_ready_i = 1'b0;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) q_a.push_back(mk(1'b0, 1'b0, 8'(i)));
         send(0, 8'(i), -1, 1'b1);
      end
      check("ovf overflow", ovf_a, 1);
      check("ovf frame_cnt", fcnt_a, 17);
      check("ovf err_cnt", ecnt_a, 0);
      pulse_clr_a();
      check("ovf clr overflow", ovf_a, 0);
      check("ovf clr frame_cnt", fcnt_a, 0);
      check("ovf clr rd_valid", if_a.rd_valid_o, 1);
      if_a.rd_ready_i = 1'b1;
      wait_drain(0, 100);

      // Receive disabled: nothing is decoded.
      en = 1'b0;
      send(0, 8'h11, -1, 1'b1);
      check("en low frame_cnt", fcnt_a, 0);
      check("en low busy", busy_a, 0);
      en = 1'b1;

      // Reset in the middle of the 4th data bit.
      q_a.push_back(mk(1'b0, 1'b0, 8'h81));
      send(0, 8'h81, -1, 1'b1);
      wait_drain(0, 20);
      check("pre-reset frame_cnt", fcnt_a, 1);
      drive(0, 1'b0, 4 * CPB + 8);
      check("mid-frame busy", busy_a, 1);
      srst = 1'b1;
      @(posedge clk);
      #1;
      srst = 1'b0;
      rx_a = 1'b1;
      check("srst busy", busy_a, 0);
      check("srst rd_valid", if_a.rd_valid_o, 0);
      check("srst frame_cnt", fcnt_a, 0);
      drive(0, 1'b1, 20);
      check("srst stays idle", busy_a, 0);
      q_a.push_back(mk(1'b0, 1'b0, 8'h3C));
      send(0, 8'h3C, -1, 1'b1);
      wait_drain(0, 20);
      check("3C frame_cnt", fcnt_a, 1);
      check("3C err_cnt", ecnt_a, 0);
      wait_drain(1, 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not complete, tests %0d failed %0d", tests, fails);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Parametrised, synthesizable UART receive monitor for the top_fpga UART loopback path, usable in bench and on FPGA.
- Oversamples a serial line, decodes configurable frames (data bits, parity, stop bits) and buffers decoded characters with per-character error flags in a FIFO behind a valid/ready read port.
- Keeps saturating frame and error counters and a sticky overflow flag, so loopback runs can be self-checked without waveform inspection.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); minimum 4.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 16, entries; power of two, minimum 2.
- CNT_W, 16, width of the frame and error counters.

Ports:
- clk  in  1  system clock.
- srst  in  1  synchronous active-high reset.
- rx_i  in  1  asynchronous serial input; idle high.
- en_i  in  1  receive enable; low forces IDLE at the next frame boundary.
- clr_i  in  1  clears counters and overflow_o.
- rd_valid_o  out  1  FIFO non-empty.
- rd_ready_i  in  1  pop request.
- rd_data_o  out  DATA_BITS  head character.
- rd_perr_o  out  1  parity error flag of head entry.
- rd_ferr_o  out  1  frame error flag of head entry.
- busy_o  out  1  FSM not in IDLE.
- overflow_o  out  1  sticky: a frame was dropped because the FIFO was full.
- frame_cnt_o  out  CNT_W  frames completed, including errored frames.
- err_cnt_o  out  CNT_W  frames with parity or frame error.

Behaviour:
- Reset:
  - All outputs 0; FIFO empty; FSM in IDLE.
  - Both synchroniser flops reset to 1.
  - Reset mid-frame aborts the frame: nothing is pushed and no counter changes.
- Input path: rx_i passes through a 2-flop synchroniser; the FSM only sees the synchronised value rxs. Latency is 2 cycles.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
  - IDLE: when en_i is 1 and rxs is 0, load the bit timer with CLKS_PER_BIT/2 - 1 and go to START.
  - START: at timer expiry sample rxs. If 1, treat as a glitch and return to IDLE with no count. If 0, reload the timer with CLKS_PER_BIT - 1 and go to DATA.
  - DATA: sample one bit at each timer expiry, LSB first, into the shift register. After DATA_BITS samples go to PAR if PARITY != 0, otherwise to STOP.
  - PAR: sample the parity bit.
    - Odd: perr = ^{data, par} == 0.
    - Even: perr = ^{data, par} == 1.
  - STOP: sample STOP_BITS bits; any 0 sets ferr.
    - On the last stop sample, push {ferr, perr, data} in that same cycle.
    - Then go to IDLE if rxs is 1, else go to BRK.
  - BRK: wait until rxs is 1, then go to IDLE. Never pushes.
- Counters:
  - frame_cnt_o increments by 1 on every last-stop-sample event.
  - err_cnt_o increments by 1 on the same event if perr or ferr is set.
  - Both saturate at all-ones.
  - If clr_i is high in the same cycle as an increment, clear wins and the result is 0.
- FIFO:
  - Read side is first-word-fall-through; rd_valid_o rises the cycle after the push.
  - A pop happens when rd_valid_o and rd_ready_i are both high.
  - Push while full without a pop: the entry is dropped and overflow_o is set. The counters still increment.
  - Push while full with a simultaneous pop: the push is accepted and the occupancy stays at FIFO_DEPTH.
  - Push and pop in the same cycle when the FIFO is empty: not possible, because rd_valid_o is 0.
- en_i low while a frame is in progress: the current frame completes, then the FSM stays in IDLE.
- busy_o is high in every state except IDLE.

Decomposition:
- Package uart_mon_pkg:
  - parity_e enum: PAR_NONE, PAR_ODD, PAR_EVEN.
  - state_e enum for the FSM.
  - Function for the entry width: DATA_BITS + 2.
- Sub-module sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: clk, srst, push, wdata, pop, rdata, full, empty.
  - Uses pointers one bit wider than the address.
- The synchroniser, timer and FSM stay in uart_rx_monitor.

Test Plan:
All scenarios use CLKS_PER_BIT = 16 and a bench UART driver. Except where a scenario states otherwise, rd_ready_i is held at 1.
- Send 0xA5 as 8N1 -> one entry: rd_data 0xA5, perr 0, ferr 0; frame_cnt 1, err_cnt 0; rd_valid rises 1 cycle after the last stop sample.
- PARITY = 2: send 0x03 with parity bit 1 (wrong) -> rd_data 0x03, perr 1, err_cnt 1. Then send 0x07 with parity bit 1 (correct) -> perr 0.
- Send 0x55 with the stop bit driven 0, then hold rx low for 40 cycles -> entry 0x55 with ferr 1; FSM stays in BRK until rx rises; no second frame.
- Pulse rx low for 4 cycles -> no push, frame_cnt 0, busy returns to 0.
- rd_ready_i held 0 while sending 17 frames with values 0x00..0x10 -> 16 entries 0x00..0x0F, overflow 1, frame_cnt 17. Then pulse clr_i -> overflow 0 and both counters 0.
- Assert srst at the 4th data bit of a frame -> FSM returns to IDLE, FIFO empty, counters 0. The next clean 0x3C is received correctly.
